// File: rtl/spi_reg_bank.sv
// Register-bank protocol engine behind spi_slave: decodes a command word, then
// auto-incrementing register writes or reads, with a 2-FF ss_n synchronizer.
module spi_reg_bank #(
  parameter int              Nbit = 8,
  parameter int              NREG = 16,
  parameter logic [Nbit-1:0] ID   = Nbit'(8'hA5)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ss_n,
  input  logic [Nbit-1:0]      rx_data,
  input  logic                 rx_strobe,
  input  logic                 tx_strobe,
  output logic [Nbit-1:0]      tx_data,
  output logic [NREG*Nbit-1:0] regs,
  output logic                 wr_valid,
  output logic [Nbit-2:0]      wr_addr,
  output logic [Nbit-1:0]      wr_data
);

  localparam int              AW   = Nbit - 1;
  localparam int              IW   = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [Nbit-1:0] LAST = Nbit'(NREG - 1);

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_t;

  state_t          state, state_nx;
  logic            ss_s1, ss_s2;
  logic [1:0]      settle;
  logic            armed;
  logic [AW-1:0]   addr;
  logic [AW-1:0]   cmd_addr;
  logic [Nbit-1:0] mem [NREG];

  assign cmd_addr = rx_data[AW-1:0];

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} <= LAST;
  endfunction

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return ({1'b0, a} >= LAST) ? '0 : a + 1'b1;
  endfunction

  function automatic logic [Nbit-1:0] read_reg(input logic [AW-1:0] a);
    return in_range(a) ? mem[a[IW-1:0]] : '0;
  endfunction

  // The synchronizer resets high, so its first two outputs after reset are not
  // genuine; a frame only starts after a real high level has been observed.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_s1  <= 1'b1;
      ss_s2  <= 1'b1;
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      ss_s1  <= ss_n;
      ss_s2  <= ss_s1;
      settle <= {settle[0], 1'b1};
      armed  <= armed | (settle[1] & ss_s2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (armed && !ss_s2) state_nx = CMD;
      CMD:     if (rx_strobe) state_nx = rx_data[Nbit-1] ? READ : WRITE;
      WRITE:   state_nx = WRITE;
      READ:    state_nx = READ;
      default: state_nx = IDLE;
    endcase
    if (ss_s2) state_nx = IDLE;
  end

  // A word arriving together with the ss_n release is still committed; the
  // ID reload below only overrides tx_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      tx_data  <= ID;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      for (int unsigned k = 0; k < NREG; k++) mem[k] <= '0;
    end else begin
      wr_valid <= 1'b0;
      case (state)
        CMD: begin
          if (rx_strobe) begin
            addr <= cmd_addr;
            if (rx_data[Nbit-1]) tx_data <= read_reg(cmd_addr);
          end
        end
        WRITE: begin
          if (rx_strobe) begin
            if (in_range(addr)) begin
              mem[addr[IW-1:0]] <= rx_data;
              wr_valid          <= 1'b1;
              wr_addr           <= addr;
              wr_data           <= rx_data;
            end
            addr <= next_addr(addr);
          end
        end
        READ: begin
          if (tx_strobe) begin
            addr    <= next_addr(addr);
            tx_data <= read_reg(next_addr(addr));
          end
        end
        default: ;
      endcase
      if (ss_s2) tx_data <= ID;
    end
  end

  always_comb begin
    regs = '0;
    for (int unsigned k = 0; k < NREG; k++) regs[k*Nbit +: Nbit] = mem[k];
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed frame table, hand-written
// reset/abort corner sequences, and random frames against a frame-level model.
module tb_spi_reg_bank;

  localparam int        NBIT = 8;
  localparam int        NREG = 16;
  localparam logic [7:0] ID  = 8'hA5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 ss_n;
  logic [NBIT-1:0]      rx_data;
  logic                 rx_strobe;
  logic                 tx_strobe;
  logic [NBIT-1:0]      tx_data;
  logic [NREG*NBIT-1:0] regs;
  logic                 wr_valid;
  logic [NBIT-2:0]      wr_addr;
  logic [NBIT-1:0]      wr_data;

  spi_reg_bank #(.Nbit(NBIT), .NREG(NREG), .ID(ID)) dut (
    .clk(clk), .rst(rst), .ss_n(ss_n), .rx_data(rx_data), .rx_strobe(rx_strobe),
    .tx_strobe(tx_strobe), .tx_data(tx_data), .regs(regs), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;

  typedef struct {
    logic [4:0][7:0] w;
    int              n;
    logic [4:0][7:0] rx;
    int              nwr;
  } vec_t;

  int         errors = 0;
  int         checks = 0;
  int         wr_seen;
  logic [7:0] mregs [NREG];
  wr_t        exp_wr [$];
  logic [7:0] exp_rx [$];
  vec_t       vecs [9];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every cycle of the bench passes through here, so any wr_valid pulse is
  // matched against the model's pending write list.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (wr_valid) begin
      wr_seen++;
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr: got addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        e = exp_wr.pop_front();
        check("wr_event", {wr_addr, wr_data}, e);
      end
    end
  endtask

  function automatic logic [127:0] mflat();
    logic [127:0] f = '0;
    for (int k = 0; k < NREG; k++) f[k*8 +: 8] = mregs[k];
    return f;
  endfunction

  function automatic logic [4:0][7:0] pk(input logic [7:0] a, b, c, d, e);
    return {e, d, c, b, a};
  endfunction

  // Frame-level model: what the master should receive for each word and which
  // writes should commit, with addresses wrapping modulo NREG.
  task automatic model_frame(input logic [4:0][7:0] w, input int n);
    int  a;
    wr_t e;
    logic is_rd;
    exp_rx.delete();
    exp_rx.push_back(ID);
    is_rd = w[0][7];
    a     = int'(w[0][6:0]);
    for (int i = 1; i < n; i++) begin
      if (is_rd) begin
        exp_rx.push_back(a < NREG ? mregs[a] : 8'h00);
      end else begin
        exp_rx.push_back(ID);
        if (a < NREG) begin
          mregs[a] = w[i];
          e.a = 7'(a);
          e.d = w[i];
          exp_wr.push_back(e);
        end
      end
      a = (a < NREG - 1) ? a + 1 : 0;
    end
  endtask

  task automatic xfer(input logic [7:0] w, input logic [7:0] exp_tx, output logic [7:0] got);
    tx_strobe = 1'b1;
    got = tx_data;
    check("tx_word", tx_data, exp_tx);
    tick();
    tx_strobe = 1'b0;
    repeat (2) tick();
    rx_data   = w;
    rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0;
    rx_data   = 8'($urandom);
    repeat (2) tick();
  endtask

  task automatic end_frame();
    ss_n = 1'b1;
    repeat (4) tick();
    check("idle_tx_id", tx_data, ID);
    check("regs", regs, mflat());
    check("wr_drained", exp_wr.size(), 0);
  endtask

  task automatic run_frame(input logic [4:0][7:0] w, input int n, output logic [4:0][7:0] got);
    logic [7:0] g;
    model_frame(w, n);
    got = '0;
    ss_n = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < n; i++) begin
      xfer(w[i], exp_rx[i], g);
      got[i] = g;
    end
    end_frame();
  endtask

  initial begin
    logic [4:0][7:0] got;
    logic [4:0][7:0] w;
    logic [7:0]      g;
    int              n;
    wr_t             e;

    vecs[0] = '{w: pk(8'h02, 8'h11, 8'h22, 8'h33, 8'h00), n: 4, rx: pk(ID, ID, ID, ID, 8'h00), nwr: 3};
    vecs[1] = '{w: pk(8'h82, 8'h00, 8'h00, 8'h00, 8'h00), n: 4, rx: pk(ID, 8'h11, 8'h22, 8'h33, 8'h00), nwr: 0};
    vecs[2] = '{w: pk(8'h0F, 8'hAA, 8'hBB, 8'h00, 8'h00), n: 3, rx: pk(ID, ID, ID, 8'h00, 8'h00), nwr: 2};
    vecs[3] = '{w: pk(8'h8F, 8'h00, 8'h00, 8'h00, 8'h00), n: 3, rx: pk(ID, 8'hAA, 8'hBB, 8'h00, 8'h00), nwr: 0};
    vecs[4] = '{w: pk(8'h20, 8'h55, 8'h00, 8'h00, 8'h00), n: 2, rx: pk(ID, ID, 8'h00, 8'h00, 8'h00), nwr: 0};
    vecs[5] = '{w: pk(8'hA0, 8'h00, 8'h00, 8'h00, 8'h00), n: 2, rx: pk(ID, 8'h00, 8'h00, 8'h00, 8'h00), nwr: 0};
    vecs[6] = '{w: pk(8'h05, 8'h00, 8'h00, 8'h00, 8'h00), n: 1, rx: pk(ID, 8'h00, 8'h00, 8'h00, 8'h00), nwr: 0};
    vecs[7] = '{w: pk(8'h84, 8'h00, 8'h00, 8'h00, 8'h00), n: 3, rx: pk(ID, 8'h33, 8'h00, 8'h00, 8'h00), nwr: 0};
    vecs[8] = '{w: pk(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00), n: 3, rx: pk(ID, 8'h00, 8'hBB, 8'h00, 8'h00), nwr: 0};

    for (int k = 0; k < NREG; k++) mregs[k] = 8'h00;
    rst = 1'b1; ss_n = 1'b1; rx_data = '0; rx_strobe = 1'b0; tx_strobe = 1'b0;
    wr_seen = 0;
    repeat (3) tick();
    check("rst_tx_data", tx_data, ID);
    check("rst_regs", regs, '0);
    check("rst_wr", {wr_valid, wr_addr, wr_data}, '0);
    rst = 1'b0;
    repeat (5) tick();

    for (int v = 0; v < 9; v++) begin
      wr_seen = 0;
      run_frame(vecs[v].w, vecs[v].n, got);
      for (int i = 0; i < vecs[v].n; i++) check("tbl_rx", got[i], vecs[v].rx[i]);
      check("tbl_wr_pulses", wr_seen, vecs[v].nwr);
    end

    // Word committed in the same cycle the synchronized ss_n goes high.
    ss_n = 1'b0;
    repeat (4) tick();
    xfer(8'h03, ID, g);
    ss_n = 1'b1;
    tick();
    tick();
    rx_data = 8'h77; rx_strobe = 1'b1;
    mregs[3] = 8'h77; e.a = 7'd3; e.d = 8'h77; exp_wr.push_back(e);
    tick();
    rx_strobe = 1'b0;
    end_frame();

    // Reset in the middle of a write burst; the rest of that frame is inert.
    ss_n = 1'b0;
    repeat (4) tick();
    mregs[6] = 8'h11; e.a = 7'd6; e.d = 8'h11; exp_wr.push_back(e);
    xfer(8'h06, ID, g);
    xfer(8'h11, ID, g);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < NREG; k++) mregs[k] = 8'h00;
    check("midrst_tx", tx_data, ID);
    check("midrst_regs", regs, '0);
    wr_seen = 0;
    repeat (4) tick();
    xfer(8'h22, ID, g);
    xfer(8'h33, ID, g);
    xfer(8'h44, ID, g);
    check("midrst_no_wr", wr_seen, 0);
    end_frame();
    run_frame(pk(8'h07, 8'h66, 8'h00, 8'h00, 8'h00), 2, got);
    run_frame(pk(8'h87, 8'h00, 8'h00, 8'h00, 8'h00), 2, got);
    check("recover_rd", got[1], 8'h66);

    for (int f = 0; f < 60; f++) begin
      n = $urandom_range(1, 5);
      w = '0;
      w[0] = {1'($urandom_range(0, 1)), 7'($urandom_range(0, NREG + 3))};
      for (int i = 1; i < 5; i++) w[i] = 8'($urandom);
      run_frame(w, n, got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Register-access protocol engine sitting directly downstream of `spi_slave`: it consumes received words (`rx_data`/`rx_strobe`), decodes a command word followed by data words, and maintains a bank of `NREG` system registers. For read commands it supplies the words `spi_slave` shifts out (`tx_data`/`tx_strobe`), so an external SPI master can read and write the bank with auto-incrementing addresses.

## Interface
- `Nbit`, 8, word width; must match the `spi_slave` instance.
- `NREG`, 16, number of registers; 1 ≤ NREG ≤ 2**(Nbit-1).
- `ID`, 8'hA5 (Nbit bits), word returned while the command word is being shifted.

- `clk` in 1: system clock, same domain as `spi_slave`.
- `rst` in 1: synchronous, active-high reset.
- `ss_n` in 1: raw SPI slave select from the bus, asynchronous to `clk`; synchronized internally with a 2-FF chain.
- `rx_data` in Nbit: received word from `spi_slave`; valid in the cycle `rx_strobe` is high.
- `rx_strobe` in 1: one-cycle pulse, word received.
- `tx_strobe` in 1: one-cycle pulse; `spi_slave` captures `tx_data` in this cycle.
- `tx_data` out Nbit: word for the next SPI transfer (registered).
- `regs` out NREG*Nbit: flattened register contents; register k is at bits [k*Nbit +: Nbit].
- `wr_valid` out 1: one-cycle pulse per committed write.
- `wr_addr` out Nbit-1: address of the committed write.
- `wr_data` out Nbit: data of the committed write.

## Operation
- Command word: bit Nbit-1 = R/nW (1 = read); bits Nbit-2:0 = start address.
- States: IDLE, CMD, WRITE, READ.
  - IDLE: wait for synchronized `ss_n` low, then go to CMD.
  - CMD: on `rx_strobe`, latch the address into `addr`; go to READ if R/nW = 1, else WRITE.
  - WRITE: each `rx_strobe` writes `rx_data` to `regs[addr]`, pulses `wr_valid`, then increments `addr`.
  - READ: `rx_data` is ignored. After each `tx_strobe`, `addr` increments and `tx_data` reloads with the new `regs[addr]`.
- Synchronized `ss_n` high, from any state: go to IDLE and load `tx_data` ← `ID`.
- `tx_data`:
  - `ID` in IDLE and CMD.
  - On the CMD→READ transition, loaded with `regs[addr]`.
  - In WRITE, held at `ID`.
- Address increment wraps NREG-1 → 0.
- Out-of-range address (≥ NREG, only possible when the command word sets it):
  - Writes are dropped: no register update, no `wr_valid`.
  - Reads return 0.
  - Increment from an out-of-range address wraps to 0.
- Command word with no following words: no side effects.
- Simultaneous `rx_strobe` and synchronized `ss_n` rising in the same cycle: the received word is processed first, then the state goes to IDLE.
- Reset (synchronous, takes precedence over everything including mid-frame):
  - State IDLE; `addr` 0; all `regs` 0.
  - `tx_data` = `ID`; `wr_valid` 0; `wr_addr` 0; `wr_data` 0.
  - The `ss_n` synchronizer flops reset to 1.

## Timing
- `ss_n` edge to state effect: 2 clk (synchronizer) + 1 clk (state register).
- `rx_strobe` in cycle t:
  - `regs` update and `wr_valid`/`wr_addr`/`wr_data` are visible at t+1.
  - On CMD→READ, `tx_data` is valid at t+1.
- `tx_strobe` in cycle t (READ): new `tx_data` valid at t+1.
- System constraint: the next `tx_strobe` arrives ≥ 2 clk after the preceding `rx_strobe` or `tx_strobe`. This holds for SCLK ≤ clk/4.
- `wr_valid` is high for exactly 1 cycle per written word, including back-to-back words.

## Test plan
- Write burst: frame 0x02, 0x11, 0x22, 0x33 → `regs[2..4]` = 11/22/33; three `wr_valid` pulses with `wr_addr` 2, 3, 4.
- Read back: frame 0x82 then 3 dummy words → master receives A5, 11, 22, 33; no `wr_valid`.
- Wrap: with NREG = 16, write 0x0F, 0xAA, 0xBB → `regs[15]` = AA, `regs[0]` = BB.
- Out of range: write 0x20, 0x55 → no `wr_valid`, `regs` unchanged; read 0xA0 → master receives A5, 00.
- Abort: raise `ss_n` after the command word 0x05 → state IDLE, `tx_data` = A5; the next frame is treated as a new command.
- Reset mid-frame: assert `rst` for 1 cycle during a write burst → all `regs` 0, `tx_data` A5, state IDLE; the remaining words of that frame cause no writes until `ss_n` has gone high and low again.
